prog_loader: RTL and testbench

Program loader that fills the CPU's instruction memory from a byte stream before execution. It is the writing end of the instruction-fetch path: it accepts a framed byte stream over a valid/ready handshake and writes (instr, arg) word pairs into instruction RAM. It holds the CPU's program counter in reset until a load completes with a correct checksum. It sits beside the instruction memory: `wr_*` drives the RAM write port, and `cpu_hold` drives the PC reset in the control unit.

---
 rtl/prog_loader_pkg.sv | 13 +
 rtl/prog_loader.sv | 75 +++++++
 tb/tb_prog_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: state encoding and checksum width shared by the program loader.
package prog_loader_pkg;
  localparam int CSUM_W = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    INSTR = 3'd2,
    ARG   = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream and writes (instr, arg) pairs into instruction RAM.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH = CSUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_instr,
  output logic [WIDTH-1:0] wr_arg,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);
  state_t state, nxt;
  logic [WIDTH-1:0] addr, rem, sum, instr;
  logic hs, restart;
  assign in_ready = state inside {LEN, INSTR, ARG, CSUM};
  assign hs       = in_valid && in_ready;
  assign restart  = start && (state inside {IDLE, DONE, ERR});
  assign done     = state == DONE;
  assign err      = state == ERR;
  assign cpu_hold = state != DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? LEN : state;
      LEN:             nxt = hs ? (in_data != '0 ? INSTR : CSUM) : LEN;
      INSTR:           nxt = hs ? ARG : INSTR;
      ARG:             nxt = hs ? (rem != WIDTH'(1) ? INSTR : CSUM) : ARG;
      CSUM:            nxt = hs ? (in_data == sum ? DONE : ERR) : CSUM;
      default:         nxt = IDLE;
    endcase
  end
  // wr_* data registers only move on an accepted arg byte, so they hold between strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr     <= '0;
      rem      <= '0;
      sum      <= '0;
      instr    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_instr <= '0;
      wr_arg   <= '0;
    end else begin
      wr_en <= hs && state == ARG;
      if (restart) begin
        addr <= '0;
        rem  <= '0;
        sum  <= '0;
      end else if (hs && state == LEN) begin
        rem <= in_data;
      end else if (hs && state == INSTR) begin
        instr <= in_data;
        sum   <= sum + in_data;
      end else if (hs && state == ARG) begin
        sum      <= sum + in_data;
        rem      <= rem - 1'b1;
        addr     <= addr + 1'b1;
        wr_addr  <= addr;
        wr_instr <= instr;
        wr_arg   <= in_data;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scenario tests for the program loader.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_en, cpu_hold, done, err;
  logic [7:0] wr_addr, wr_instr, wr_arg;
  int cmp = 0;
  int errs = 0;
  int stalls = 0;
  logic [7:0] qa[$], qi[$], qg[$];

  prog_loader #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_instr(wr_instr),
    .wr_arg(wr_arg), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (wr_en) begin
      qa.push_back(wr_addr);
      qi.push_back(wr_instr);
      qg.push_back(wr_arg);
    end

  task automatic clear_log();
    qa.delete();
    qi.delete();
    qg.delete();
    stalls = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      stalls++;
    end
    if (n >= 20) begin
      cmp++;
      errs++;
      $display("FAIL send_timeout in_ready=%b want 1 byte=%h", in_ready, b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    cmp++; if ({in_ready, wr_en, cpu_hold, done, err} !== 5'b00100) begin errs++;
      $display("FAIL reset_ctrl got %b want 00100", {in_ready, wr_en, cpu_hold, done, err}); end
    cmp++; if ({wr_addr, wr_instr, wr_arg} !== 24'h0) begin errs++;
      $display("FAIL reset_data got %h want 000000", {wr_addr, wr_instr, wr_arg}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_start();
    send(8'h01, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    cmp++; if (wr_en !== 1'b1) begin errs++;
      $display("FAIL pre_reset_wr_en got %b want 1", wr_en); end
    rst_n = 1'b0;
    #1;
    cmp++; if ({in_ready, wr_en, cpu_hold, done, err} !== 5'b00100) begin errs++;
      $display("FAIL async_reset_ctrl got %b want 00100", {in_ready, wr_en, cpu_hold, done, err}); end
    cmp++; if ({wr_addr, wr_instr, wr_arg} !== 24'h0) begin errs++;
      $display("FAIL async_reset_data got %h want 000000", {wr_addr, wr_instr, wr_arg}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good();
    clear_log();
    do_start();
    cmp++; if ({in_ready, cpu_hold, done, err} !== 4'b1100) begin errs++;
      $display("FAIL good_start got %b want 1100", {in_ready, cpu_hold, done, err}); end
    send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
    send(8'h33, 0); send(8'h44, 0); send(8'hAA, 0);
    cmp++; if ({done, err, cpu_hold, in_ready} !== 4'b1000) begin errs++;
      $display("FAIL good_done got %b want 1000", {done, err, cpu_hold, in_ready}); end
    cmp++; if (stalls !== 0) begin errs++;
      $display("FAIL good_throughput stalls=%0d want 0", stalls); end
    cmp++; if (qa.size() !== 2) begin errs++;
      $display("FAIL good_wr_count got %0d want 2", qa.size()); end
    else begin
      cmp++; if ({qa[0], qi[0], qg[0]} !== 24'h001122) begin errs++;
        $display("FAIL good_wr0 got %h want 001122", {qa[0], qi[0], qg[0]}); end
      cmp++; if ({qa[1], qi[1], qg[1]} !== 24'h013344) begin errs++;
        $display("FAIL good_wr1 got %h want 013344", {qa[1], qi[1], qg[1]}); end
    end
    cmp++; if ({wr_en, wr_addr, wr_instr, wr_arg} !== 25'h0013344) begin errs++;
      $display("FAIL good_hold got %h want 0013344", {wr_en, wr_addr, wr_instr, wr_arg}); end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    do_start();
    cmp++; if ({done, cpu_hold, in_ready} !== 3'b011) begin errs++;
      $display("FAIL bad_restart got %b want 011", {done, cpu_hold, in_ready}); end
    send(8'h02, 0); send(8'h11, 0); send(8'h22, 0);
    send(8'h33, 0); send(8'h44, 0); send(8'hAB, 0);
    cmp++; if ({err, cpu_hold, done} !== 3'b110) begin errs++;
      $display("FAIL bad_err got %b want 110", {err, cpu_hold, done}); end
    cmp++; if (qa.size() !== 2) begin errs++;
      $display("FAIL bad_wr_count got %0d want 2", qa.size()); end
    repeat (3) @(posedge clk);
    #1;
    cmp++; if ({err, cpu_hold} !== 2'b11) begin errs++;
      $display("FAIL bad_sticky got %b want 11", {err, cpu_hold}); end
    do_start();
    cmp++; if ({err, in_ready} !== 2'b01) begin errs++;
      $display("FAIL bad_clear got %b want 01", {err, in_ready}); end
  endtask

  task automatic test_empty();
    clear_log();
    send(8'h00, 0);
    start = 1'b1;
    send(8'h00, 0);
    cmp++; if ({done, err, cpu_hold, in_ready} !== 4'b1000) begin errs++;
      $display("FAIL empty_done got %b want 1000", {done, err, cpu_hold, in_ready}); end
    @(posedge clk);
    #1 start = 1'b0;
    cmp++; if ({done, in_ready} !== 2'b01) begin errs++;
      $display("FAIL empty_restart got %b want 01", {done, in_ready}); end
    send(8'h00, 0);
    send(8'h01, 0);
    cmp++; if ({err, done, cpu_hold} !== 3'b101) begin errs++;
      $display("FAIL empty_err got %b want 101", {err, done, cpu_hold}); end
    cmp++; if (qa.size() !== 0) begin errs++;
      $display("FAIL empty_no_wr got %0d want 0", qa.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] k;
    clear_log();
    do_start();
    send(8'hFF, $urandom_range(0, 2));
    for (int i = 0; i < 255; i++) begin
      k = 8'(i);
      send(k, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      send(~k, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    send(8'h01, 1);
    cmp++; if ({done, err, cpu_hold} !== 3'b100) begin errs++;
      $display("FAIL bp_done got %b want 100", {done, err, cpu_hold}); end
    cmp++; if (qa.size() !== 255) begin errs++;
      $display("FAIL bp_wr_count got %0d want 255", qa.size()); end
    else
      for (int i = 0; i < 255; i++) begin
        k = 8'(i);
        cmp++; if ({qa[i], qi[i], qg[i]} !== {k, k, ~k}) begin errs++;
          $display("FAIL bp_wr%0d got %h want %h", i, {qa[i], qi[i], qg[i]}, {k, k, ~k}); end
      end
    cmp++; if (wr_addr !== 8'hFE) begin errs++;
      $display("FAIL bp_last_addr got %h want fe", wr_addr); end
  endtask

  task automatic test_start_mid_frame();
    clear_log();
    do_start();
    send(8'h01, 0);
    start = 1'b1;
    send(8'h12, 0);
    start = 1'b0;
    send(8'h34, 0);
    cmp++; if (in_ready !== 1'b1) begin errs++;
      $display("FAIL mid_csum_ready got %b want 1", in_ready); end
    send(8'h46, 0);
    cmp++; if ({done, err, cpu_hold} !== 3'b100) begin errs++;
      $display("FAIL mid_done got %b want 100", {done, err, cpu_hold}); end
    cmp++; if (qa.size() !== 1) begin errs++;
      $display("FAIL mid_wr_count got %0d want 1", qa.size()); end
    else begin
      cmp++; if ({qa[0], qi[0], qg[0]} !== 24'h001234) begin errs++;
        $display("FAIL mid_wr0 got %h want 001234", {qa[0], qi[0], qg[0]}); end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_checksum();
    test_empty();
    test_backpressure();
    test_start_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
